ov7670_capture: RTL and testbench

- Capture front end for the OV7670 path, clocked by the camera pixel clock.
- Samples raw VSYNC/HREF/D[7:0], pairs bytes into RGB565 pixels, and crops a 256x256 window out of the 640x480 VGA frame.
- Drives the frame buffer's write port (data, 16-bit linear address, write strobe) and its frame-ready level that starts the buffer's copy into display memory.
- Runt or oversized frames are flagged and never marked ready.

---
 rtl/ov7670_capture.sv | 162 ++++++++++++++++
 tb/tb_ov7670_capture.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// OV7670 capture: registers VSYNC/HREF/D, pairs bytes into RGB565, crops a window, drives buffer write port.
// Latency: pixel strobe 2 PCLK edges after its second byte; no backpressure (camera cannot stall).
module ov7670_capture #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CROP_X0  = 192,
   parameter int CROP_Y0  = 112,
   parameter int CROP_W   = 256,
   parameter int CROP_H   = 256
) (
   input  logic        w_clk,
   input  logic        rst,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_d,
   output logic [15:0] d_in_a,
   output logic [15:0] w_addr,
   output logic        w_en_a,
   output logic        r_rd,
   output logic        frame_err,
   output logic [1:0]  led_d
);

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      FRAME = 2'd1,
      READY = 2'd2
   } state_t;

   localparam logic [10:0] CNT_MAX = 11'h7FF;
   localparam logic [10:0] H_CNT   = 11'(H_ACTIVE);
   localparam logic [10:0] V_CNT   = 11'(V_ACTIVE);
   localparam logic [10:0] X_LO    = 11'(CROP_X0);
   localparam logic [10:0] X_HI    = 11'(CROP_X0 + CROP_W);
   localparam logic [10:0] Y_LO    = 11'(CROP_Y0);
   localparam logic [10:0] Y_HI    = 11'(CROP_Y0 + CROP_H);

   state_t      state, state_nxt;
   logic        vs_r, hr_r, vs_p, hr_p;
   logic [7:0]  d_r, hi_byte;
   logic [10:0] col, row;
   logic        phase, line_err;

   logic        vs_rise, vs_fall, hr_rise, hr_fall;
   logic        enter_frame, end_frame;
   logic        pix_phase, in_crop, line_bad_now, frame_good;
   logic [10:0] col_inc, row_inc, rows_done;
   logic [7:0]  col_off, row_off;

   assign vs_rise = vs_r & ~vs_p;
   assign vs_fall = ~vs_r & vs_p;
   assign hr_rise = hr_r & ~hr_p;
   assign hr_fall = ~hr_r & hr_p;

   always_comb begin
      state_nxt   = state;
      enter_frame = 1'b0;
      end_frame   = 1'b0;
      case (state)
         SYNC: begin
            if (vs_fall) begin
               state_nxt   = FRAME;
               enter_frame = 1'b1;
            end
         end
         FRAME: begin
            if (vs_rise) begin
               state_nxt = READY;
               end_frame = 1'b1;
            end
         end
         READY: begin
            if (vs_fall) begin
               state_nxt   = FRAME;
               enter_frame = 1'b1;
            end
         end
         default: state_nxt = SYNC;
      endcase
   end

   // The first HREF-high cycle always carries a high byte, whatever phase was left over.
   assign pix_phase = hr_rise ? 1'b0 : phase;

   assign col_inc   = (col == CNT_MAX) ? col : col + 11'd1;
   assign row_inc   = (row == CNT_MAX) ? row : row + 11'd1;
   assign col_off   = 8'(col - X_LO);
   assign row_off   = 8'(row - Y_LO);
   assign in_crop   = (col >= X_LO) && (col < X_HI) && (row >= Y_LO) && (row < Y_HI);

   // A line that ends in the same cycle VSYNC rises must still count toward the frame verdict.
   assign line_bad_now = hr_fall && ((col != H_CNT) || phase);
   assign rows_done    = hr_fall ? row_inc : row;
   assign frame_good   = (rows_done == V_CNT) && !line_err && !line_bad_now && !hr_r;

   always_ff @(posedge w_clk) begin
      if (rst) begin
         state     <= SYNC;
         vs_r      <= 1'b0;
         hr_r      <= 1'b0;
         vs_p      <= 1'b0;
         hr_p      <= 1'b0;
         d_r       <= 8'd0;
         hi_byte   <= 8'd0;
         col       <= 11'd0;
         row       <= 11'd0;
         phase     <= 1'b0;
         line_err  <= 1'b0;
         d_in_a    <= 16'd0;
         w_addr    <= 16'd0;
         w_en_a    <= 1'b0;
         r_rd      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state  <= state_nxt;
         vs_r   <= cam_vsync;
         hr_r   <= cam_href;
         d_r    <= cam_d;
         vs_p   <= vs_r;
         hr_p   <= hr_r;
         w_en_a <= 1'b0;
         if (enter_frame) begin
            col       <= 11'd0;
            row       <= 11'd0;
            phase     <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            r_rd      <= 1'b0;
         end else if (end_frame) begin
            r_rd      <= frame_good;
            frame_err <= !frame_good;
         end else if (state == FRAME) begin
            if (hr_r) begin
               if (hr_rise) begin
                  col <= 11'd0;
               end
               if (!pix_phase) begin
                  hi_byte <= d_r;
                  phase   <= 1'b1;
               end else begin
                  phase <= 1'b0;
                  col   <= col_inc;
                  if (in_crop) begin
                     d_in_a <= {hi_byte, d_r};
                     w_addr <= {row_off, col_off};
                     w_en_a <= 1'b1;
                  end
               end
            end else if (hr_fall) begin
               if (line_bad_now) begin
                  line_err <= 1'b1;
               end
               row   <= row_inc;
               phase <= 1'b0;
            end
         end
      end
   end

   assign led_d = state;

endmodule

// File: tb/tb_ov7670_capture.sv
// Scoreboard bench for ov7670_capture on a scaled-down frame geometry with randomized pixel bytes.
module tb_ov7670_capture;
   localparam int H  = 16;
   localparam int V  = 12;
   localparam int X0 = 4;
   localparam int Y0 = 3;
   localparam int CW = 8;
   localparam int CH = 6;

   logic        w_clk = 1'b0;
   logic        rst;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_d;
   logic [15:0] d_in_a;
   logic [15:0] w_addr;
   logic        w_en_a;
   logic        r_rd;
   logic        frame_err;
   logic [1:0]  led_d;

   ov7670_capture #(
      .H_ACTIVE(H), .V_ACTIVE(V), .CROP_X0(X0), .CROP_Y0(Y0), .CROP_W(CW), .CROP_H(CH)
   ) dut (
      .w_clk(w_clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
      .d_in_a(d_in_a), .w_addr(w_addr), .w_en_a(w_en_a), .r_rd(r_rd),
      .frame_err(frame_err), .led_d(led_d)
   );

   always #5 w_clk = ~w_clk;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pix;
   logic        prev_en = 1'b0;
   bit          armed = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: every strobe must match the oldest expected write, and never be back-to-back.
   always @(negedge w_clk) begin
      if (w_en_a === 1'b1) begin
         check("strobe_gap", 32'(prev_en), 32'd0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got addr=%h data=%h, required no strobe", w_addr, d_in_a);
         end else begin
            exp_pix = exp_q.pop_front();
            check("pixel", {w_addr, d_in_a}, exp_pix);
         end
      end
      prev_en = w_en_a;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge w_clk);
   endtask

   // Reference: a line of n bytes yields floor(n/2) pixels {b[2c], b[2c+1]}; those inside the crop are written.
   task automatic send_line(input int r, input int nbytes, input bit pattern);
      logic [7:0] b[$];
      for (int i = 0; i < nbytes; i++) begin
         if (pattern) b.push_back((i % 2 == 0) ? 8'(r) : 8'(i / 2));
         else         b.push_back(8'($urandom));
      end
      if (armed) begin
         for (int c = 0; c < nbytes / 2; c++) begin
            if (r >= Y0 && r < Y0 + CH && c >= X0 && c < X0 + CW)
               exp_q.push_back({8'(r - Y0), 8'(c - X0), b[2 * c], b[2 * c + 1]});
         end
      end
      for (int i = 0; i < nbytes; i++) begin
         @(negedge w_clk);
         cam_href = 1'b1;
         cam_d    = b[i];
      end
      @(negedge w_clk);
      cam_href = 1'b0;
      cam_d    = 8'($urandom);
      tick($urandom_range(0, 3));
   endtask

   task automatic frame_start();
      @(negedge w_clk);
      cam_vsync = 1'b0;
      armed     = 1'b1;
      tick(2);
      check("led_frame", 32'(led_d), 32'd1);
      check("r_rd_drop", 32'(r_rd), 32'd0);
      tick($urandom_range(1, 3));
   endtask

   task automatic frame_end(input bit good);
      @(negedge w_clk);
      cam_vsync = 1'b1;
      @(negedge w_clk);
      check("r_rd_early", 32'(r_rd), 32'd0);
      @(negedge w_clk);
      check("led_end", 32'(led_d), armed ? 32'd2 : 32'd0);
      check("r_rd", 32'(r_rd), 32'(good && armed));
      check("frame_err", 32'(frame_err), 32'(!good && armed));
      check("drain", 32'(exp_q.size()), 32'd0);
      tick($urandom_range(0, 4));
   endtask

   task automatic run_frame(input int nlines, input int bad_row, input int bad_bytes, input bit pattern);
      frame_start();
      for (int r = 0; r < nlines; r++)
         send_line(r, (r == bad_row) ? bad_bytes : 2 * H, pattern);
      frame_end(nlines == V && (bad_row < 0 || bad_bytes == 2 * H));
   endtask

   // Reset during a line gap: capture must stay off for the remainder of the frame.
   task automatic reset_mid_frame(input int at_line, input int rst_len);
      frame_start();
      for (int r = 0; r < at_line; r++) send_line(r, 2 * H, 1'b0);
      tick(2);
      check("drain_before_rst", 32'(exp_q.size()), 32'd0);
      rst = 1'b1;
      tick(1);
      check("rst_w_en", 32'(w_en_a), 32'd0);
      check("rst_r_rd", 32'(r_rd), 32'd0);
      check("rst_led", 32'(led_d), 32'd0);
      tick(rst_len - 1);
      rst   = 1'b0;
      armed = 1'b0;
      for (int r = at_line; r < V; r++) send_line(r, 2 * H, 1'b0);
      frame_end(1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      cam_vsync = 1'b1;
      cam_href  = 1'b0;
      cam_d     = 8'd0;
      tick(3);
      check("rst_d_in_a", 32'(d_in_a), 32'd0);
      check("rst_w_addr", 32'(w_addr), 32'd0);
      check("rst_w_en_a", 32'(w_en_a), 32'd0);
      check("rst_r_rd", 32'(r_rd), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_led_d", 32'(led_d), 32'd0);
      rst = 1'b0;
      tick(3);

      run_frame(V, -1, 0, 1'b1);
      run_frame(V, -1, 0, 1'b0);
      run_frame(V, Y0 + 2, 2 * H - 2, 1'b0);
      run_frame(V, -1, 0, 1'b0);
      run_frame(V, Y0 + 1, 2 * H + 1, 1'b0);
      run_frame(V, Y0 + 3, 2 * H + 2, 1'b0);
      run_frame(V, Y0, 7, 1'b0);
      run_frame(V - 1, -1, 0, 1'b0);
      run_frame(V + 1, -1, 0, 1'b0);
      run_frame(V, -1, 0, 1'b1);

      // VSYNC rises while HREF is still high on an extra line after a full frame.
      frame_start();
      for (int r = 0; r < V; r++) send_line(r, 2 * H, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge w_clk);
         cam_href = 1'b1;
         cam_d    = 8'($urandom);
      end
      @(negedge w_clk);
      cam_vsync = 1'b1;
      @(negedge w_clk);
      cam_href = 1'b0;
      @(negedge w_clk);
      check("midline_led", 32'(led_d), 32'd2);
      check("midline_r_rd", 32'(r_rd), 32'd0);
      check("midline_err", 32'(frame_err), 32'd1);
      tick(3);

      reset_mid_frame(Y0 + 2, 1);
      run_frame(V, -1, 0, 1'b0);
      reset_mid_frame(V / 2, 4);
      run_frame(V, -1, 0, 1'b1);

      tick(5);
      check("final_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
